rob_multi: RTL

- Parametrised successor to the single-issue reorder buffer: in-order allocation, out-of-order completion over WB_PORTS writeback channels, and one in-order commit per cycle.
- Sits between the dispatcher (allocation, operand lookup), the execution units (writeback), the regfile (commit), the data controller (store commit) and branch prediction / fetch (redirect).
- Every slot is usable: wrap-bit pointers distinguish full from empty, and tag values run 0..DEPTH-1.

---
 rtl/rob_pkg.sv | 38 +++
 rtl/rob_fwd_scan.sv | 51 +++++
 rtl/rob_multi.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rob_pkg.sv
// Shared types for the multi-writeback reorder buffer.
// Contents:
//   rob_kind_e  - entry kind as encoded on the dispatcher's alloc_kind_in bus
//   rob_entry_t - one buffer entry; field widths are set by the Rob*W localparams
//   st_state_e  - store-commit handshake state
// The entry struct is sized here, so a top-level instance must keep DATA_W, ADDR_W and
// REG_W equal to RobDataW, RobAddrW and RobRegW.
package rob_pkg;

  localparam int unsigned RobDataW = 32;
  localparam int unsigned RobAddrW = 32;
  localparam int unsigned RobRegW  = 5;

  typedef enum logic [1:0] {
    KindReg    = 2'd0,
    KindBranch = 2'd1,
    KindStore  = 2'd2,
    KindJalr   = 2'd3
  } rob_kind_e;

  typedef struct packed {
    logic                busy;
    logic                ready;
    rob_kind_e           kind;
    logic [RobRegW-1:0]  dest;
    logic [RobAddrW-1:0] pc;
    logic [RobAddrW-1:0] target;  // predicted target; for JALR, the resolved target
    logic                taken;   // predicted-taken bit
    logic [RobDataW-1:0] value;   // result; for BRANCH, bit 0 is the actual direction
    logic [RobAddrW-1:0] addr;    // store address
  } rob_entry_t;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StReq  = 1'b1
  } st_state_e;

endpackage

// File: rtl/rob_fwd_scan.sv
// Older-store scan used for load forwarding.
// Walks the buffer from the head in age order and reports the youngest busy STORE that is
// older than the load and whose address matches it.
// Ports:
//   entries_in    - full buffer contents
//   head_in       - head slot index (oldest entry)
//   ld_tag_in     - tag of the querying load
//   ld_addr_in    - load address
//   conflict_out  - a matching older store exists
//   fwd_valid_out - that store's data is ready
//   fwd_data_out  - that store's data
module rob_fwd_scan
  import rob_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DATA_W = RobDataW,
  parameter int unsigned ADDR_W = RobAddrW,
  parameter int unsigned TAG_W  = $clog2(DEPTH)
) (
  input  rob_entry_t        entries_in [DEPTH],
  input  logic [TAG_W-1:0]  head_in,
  input  logic [TAG_W-1:0]  ld_tag_in,
  input  logic [ADDR_W-1:0] ld_addr_in,
  output logic              conflict_out,
  output logic              fwd_valid_out,
  output logic [DATA_W-1:0] fwd_data_out
);

  logic [TAG_W-1:0] ld_age;
  logic [TAG_W-1:0] scan_idx;

  always_comb begin
    conflict_out  = 1'b0;
    fwd_valid_out = 1'b0;
    fwd_data_out  = '0;
    ld_age        = ld_tag_in - head_in;
    scan_idx      = head_in;
    // Oldest first, so the last hit is the youngest matching store.
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = head_in + TAG_W'(i);
      if (TAG_W'(i) < ld_age && entries_in[scan_idx].busy &&
          entries_in[scan_idx].kind == KindStore &&
          entries_in[scan_idx].addr == ld_addr_in) begin
        conflict_out  = 1'b1;
        fwd_valid_out = entries_in[scan_idx].ready;
        fwd_data_out  = entries_in[scan_idx].value;
      end
    end
  end

endmodule

// File: rtl/rob_multi.sv
// Reorder buffer: in-order allocation, out-of-order completion over WB_PORTS writeback
// channels, one in-order commit per cycle, branch resolution and store handshake.
// Ports:
//   clk_in, rst_in (sync, active-high), rdy_in (global enable)
//   alloc_*    - dispatcher allocation handshake; alloc_tag_out is the slot assigned
//   wb_*       - per-channel writeback (value, and target for JALR entries)
//   sa_*       - store-address write
//   rs_*, rt_* - combinational operand lookup with writeback bypass
//   commit_*   - registered regfile write
//   bp_*       - registered branch-resolution report
//   flush_out, redirect_pc_out - registered fetch redirect
//   st_*       - store request handshake with the data controller
//   count_out  - occupancy
//   ld_*       - older-store query for loads
// Optional build macro ROB_LOAD_FWD_EN: address-matched store-to-load forwarding. Without it
// ld_conflict_out flags any older busy STORE and forwarding is never valid.
module rob_multi
  import rob_pkg::*;
#(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned WB_PORTS = 3,
  parameter int unsigned DATA_W   = RobDataW,
  parameter int unsigned ADDR_W   = RobAddrW,
  parameter int unsigned REG_W    = RobRegW,
  parameter int unsigned TAG_W    = $clog2(DEPTH)
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       rdy_in,
  input  logic                       alloc_valid_in,
  output logic                       alloc_ready_out,
  input  logic [1:0]                 alloc_kind_in,
  input  logic [REG_W-1:0]           alloc_dest_in,
  input  logic [ADDR_W-1:0]          alloc_pc_in,
  input  logic [ADDR_W-1:0]          alloc_target_in,
  input  logic                       alloc_taken_in,
  output logic [TAG_W-1:0]           alloc_tag_out,
  input  logic [WB_PORTS-1:0]        wb_valid_in,
  input  logic [WB_PORTS*TAG_W-1:0]  wb_tag_in,
  input  logic [WB_PORTS*DATA_W-1:0] wb_data_in,
  input  logic [WB_PORTS*ADDR_W-1:0] wb_addr_in,
  input  logic                       sa_valid_in,
  input  logic [TAG_W-1:0]           sa_tag_in,
  input  logic [ADDR_W-1:0]          sa_addr_in,
  input  logic [TAG_W-1:0]           rs_tag_in,
  input  logic [TAG_W-1:0]           rt_tag_in,
  output logic                       rs_ready_out,
  output logic                       rt_ready_out,
  output logic [DATA_W-1:0]          rs_value_out,
  output logic [DATA_W-1:0]          rt_value_out,
  output logic                       commit_en_out,
  output logic [REG_W-1:0]           commit_dest_out,
  output logic [DATA_W-1:0]          commit_value_out,
  output logic [TAG_W-1:0]           commit_tag_out,
  output logic                       bp_en_out,
  output logic                       bp_correct_out,
  output logic [ADDR_W-1:0]          bp_pc_out,
  output logic                       flush_out,
  output logic [ADDR_W-1:0]          redirect_pc_out,
  output logic                       st_valid_out,
  output logic [ADDR_W-1:0]          st_addr_out,
  output logic [DATA_W-1:0]          st_data_out,
  input  logic                       st_done_in,
  output logic [TAG_W:0]             count_out,
  input  logic [TAG_W-1:0]           ld_tag_in,
  input  logic [ADDR_W-1:0]          ld_addr_in,
  output logic                       ld_conflict_out,
  output logic                       ld_fwd_valid_out,
  output logic [DATA_W-1:0]          ld_fwd_data_out
);

  localparam int unsigned PTR_W = TAG_W + 1;

  rob_entry_t        entries_q [DEPTH];
  rob_entry_t        entries_d [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  st_state_e         st_state_q, st_state_d;
  logic              commit_en_q, commit_en_d;
  logic [REG_W-1:0]  commit_dest_q, commit_dest_d;
  logic [DATA_W-1:0] commit_value_q, commit_value_d;
  logic [TAG_W-1:0]  commit_tag_q, commit_tag_d;
  logic              bp_en_q, bp_en_d;
  logic              bp_correct_q, bp_correct_d;
  logic [ADDR_W-1:0] bp_pc_q, bp_pc_d;
  logic              flush_q, flush_d;
  logic [ADDR_W-1:0] redirect_q, redirect_d;

  logic [TAG_W-1:0]  head_idx, tail_idx, wb_tag;
  logic [PTR_W-1:0]  count;
  rob_entry_t        head_e;
  logic              head_valid, head_flush, alloc_fire, retire;

  assign head_idx   = head_q[TAG_W-1:0];
  assign tail_idx   = tail_q[TAG_W-1:0];
  // Wrap bits make tail - head range over 0..DEPTH.
  assign count      = tail_q - head_q;
  assign head_e     = entries_q[head_idx];
  assign head_valid = head_e.busy && head_e.ready && (st_state_q == StIdle);
  // A mispredicted branch or any JALR at the head empties the buffer at the next edge.
  assign head_flush = head_valid && ((head_e.kind == KindJalr) ||
                      (head_e.kind == KindBranch && head_e.value[0] != head_e.taken));

  assign alloc_ready_out = (count < PTR_W'(DEPTH)) && !head_flush;
  assign alloc_fire      = rdy_in && alloc_valid_in && alloc_ready_out;
  assign alloc_tag_out   = tail_idx;
  assign count_out       = count;

  // Bypass mirrors writeback acceptance: only busy, not-yet-ready entries take it.
  function automatic logic [DATA_W:0] lookup(input logic [TAG_W-1:0] tag);
    logic [DATA_W:0] res;
    res = {entries_q[tag].busy && entries_q[tag].ready, entries_q[tag].value};
    for (int w = WB_PORTS - 1; w >= 0; w--) begin
      if (wb_valid_in[w] && wb_tag_in[w*TAG_W +: TAG_W] == tag &&
          entries_q[tag].busy && !entries_q[tag].ready) begin
        res = {1'b1, wb_data_in[w*DATA_W +: DATA_W]};
      end
    end
    return res;
  endfunction

  assign {rs_ready_out, rs_value_out} = lookup(rs_tag_in);
  assign {rt_ready_out, rt_value_out} = lookup(rt_tag_in);

  always_comb begin
    entries_d      = entries_q;
    head_d         = head_q;
    tail_d         = tail_q;
    st_state_d     = st_state_q;
    commit_en_d    = 1'b0;
    commit_dest_d  = commit_dest_q;
    commit_value_d = commit_value_q;
    commit_tag_d   = commit_tag_q;
    bp_en_d        = 1'b0;
    bp_correct_d   = 1'b0;
    bp_pc_d        = bp_pc_q;
    flush_d        = 1'b0;
    redirect_d     = redirect_q;
    wb_tag         = '0;
    retire         = 1'b0;

    if (rdy_in) begin
      if (alloc_fire) begin
        entries_d[tail_idx] = '{busy: 1'b1, ready: 1'b0, kind: rob_kind_e'(alloc_kind_in),
                                dest: alloc_dest_in, pc: alloc_pc_in,
                                target: alloc_target_in, taken: alloc_taken_in,
                                value: '0, addr: '0};
        tail_d = tail_q + PTR_W'(1);
      end

      // Highest channel first so the lowest channel's write lands last and wins.
      for (int w = WB_PORTS - 1; w >= 0; w--) begin
        wb_tag = wb_tag_in[w*TAG_W +: TAG_W];
        if (wb_valid_in[w] && entries_q[wb_tag].busy && !entries_q[wb_tag].ready) begin
          entries_d[wb_tag].value = wb_data_in[w*DATA_W +: DATA_W];
          entries_d[wb_tag].ready = 1'b1;
          if (entries_q[wb_tag].kind == KindJalr) begin
            entries_d[wb_tag].target = wb_addr_in[w*ADDR_W +: ADDR_W];
          end
        end
      end

      if (sa_valid_in && entries_q[sa_tag_in].busy) begin
        entries_d[sa_tag_in].addr = sa_addr_in;
      end

      unique case (st_state_q)
        StIdle: begin
          if (head_valid) begin
            unique case (head_e.kind)
              KindReg: begin
                commit_en_d    = 1'b1;
                commit_dest_d  = head_e.dest;
                commit_value_d = head_e.value;
                commit_tag_d   = head_idx;
                retire         = 1'b1;
              end
              KindBranch: begin
                bp_en_d = 1'b1;
                bp_pc_d = head_e.pc;
                if (!head_flush) begin
                  bp_correct_d = 1'b1;
                  retire       = 1'b1;
                end else begin
                  redirect_d = head_e.value[0] ? head_e.target : head_e.pc + ADDR_W'(4);
                end
              end
              KindJalr: begin
                commit_en_d    = 1'b1;
                commit_dest_d  = head_e.dest;
                commit_value_d = head_e.value;
                commit_tag_d   = head_idx;
                redirect_d     = head_e.target;
              end
              KindStore: st_state_d = StReq;
              default: ;
            endcase
          end
        end
        StReq: begin
          if (st_done_in) begin
            retire     = 1'b1;
            st_state_d = StIdle;
          end
        end
        default: st_state_d = StIdle;
      endcase

      if (retire) begin
        entries_d[head_idx].busy  = 1'b0;
        entries_d[head_idx].ready = 1'b0;
        head_d = head_q + PTR_W'(1);
      end

      // Flush overrides this cycle's allocation and writebacks.
      if (head_flush) begin
        flush_d = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
          entries_d[i].busy  = 1'b0;
          entries_d[i].ready = 1'b0;
        end
        head_d = '0;
        tail_d = '0;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      entries_q      <= '{default: '0};
      head_q         <= '0;
      tail_q         <= '0;
      st_state_q     <= StIdle;
      commit_en_q    <= 1'b0;
      commit_dest_q  <= '0;
      commit_value_q <= '0;
      commit_tag_q   <= '0;
      bp_en_q        <= 1'b0;
      bp_correct_q   <= 1'b0;
      bp_pc_q        <= '0;
      flush_q        <= 1'b0;
      redirect_q     <= '0;
    end else begin
      entries_q      <= entries_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      st_state_q     <= st_state_d;
      commit_en_q    <= commit_en_d;
      commit_dest_q  <= commit_dest_d;
      commit_value_q <= commit_value_d;
      commit_tag_q   <= commit_tag_d;
      bp_en_q        <= bp_en_d;
      bp_correct_q   <= bp_correct_d;
      bp_pc_q        <= bp_pc_d;
      flush_q        <= flush_d;
      redirect_q     <= redirect_d;
    end
  end

  assign commit_en_out    = commit_en_q;
  assign commit_dest_out  = commit_dest_q;
  assign commit_value_out = commit_value_q;
  assign commit_tag_out   = commit_tag_q;
  assign bp_en_out        = bp_en_q;
  assign bp_correct_out   = bp_correct_q;
  assign bp_pc_out        = bp_pc_q;
  assign flush_out        = flush_q;
  assign redirect_pc_out  = redirect_q;

  // The head cannot move while a store is outstanding, so address/data stay stable.
  assign st_valid_out = (st_state_q == StReq);
  assign st_addr_out  = st_valid_out ? head_e.addr : '0;
  assign st_data_out  = st_valid_out ? head_e.value : '0;

`ifdef ROB_LOAD_FWD_EN
  rob_fwd_scan #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .TAG_W  (TAG_W)
  ) u_fwd_scan (
    .entries_in    (entries_q),
    .head_in       (head_idx),
    .ld_tag_in     (ld_tag_in),
    .ld_addr_in    (ld_addr_in),
    .conflict_out  (ld_conflict_out),
    .fwd_valid_out (ld_fwd_valid_out),
    .fwd_data_out  (ld_fwd_data_out)
  );
`else
  logic [TAG_W-1:0] ld_age, scan_idx;
  logic             unused_ld_addr;

  assign unused_ld_addr = ^ld_addr_in;

  // Conservative: any older busy STORE blocks the load, whatever its address.
  always_comb begin
    ld_conflict_out = 1'b0;
    ld_age          = ld_tag_in - head_idx;
    scan_idx        = head_idx;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = head_idx + TAG_W'(i);
      if (TAG_W'(i) < ld_age && entries_q[scan_idx].busy &&
          entries_q[scan_idx].kind == KindStore) begin
        ld_conflict_out = 1'b1;
      end
    end
  end

  assign ld_fwd_valid_out = 1'b0;
  assign ld_fwd_data_out  = '0;
`endif

endmodule
